// File: rtl/pmod_da2_pkg.sv
// Shared types and constants for the PmodDA2 serial transmitter.
// Holds the FSM state enum, frame geometry, power-down codes and frame packing.
package pmod_da2_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } tx_state_e;

  // Offset binary is two's complement with the sign bit flipped.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_W-1:0] din,
                                                       input logic              signed_in,
                                                       input logic [1:0]        pd);
    logic [DATA_W-1:0] code;
    code = signed_in ? {~din[DATA_W-1], din[DATA_W-2:0]} : din;
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Free-running SClk divider; rise/fall strobes are asserted in the clk cycle
// whose closing edge toggles the registered SClk.
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic Reset,
  output logic sclk_o,
  output logic rise_ev_o,
  output logic fall_ev_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;
  logic          tc;

  assign tc = (div_cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d = tc ? '0 : div_cnt_q + CW'(1);
    sclk_d    = tc ? ~sclk_q : sclk_q;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign rise_ev_o = tc & ~sclk_q;
  assign fall_ev_o = tc & sclk_q;

endmodule

// File: rtl/pmod_da2_tx.sv
// PmodDA2 dual-DAC transmitter: accepts a sample pair, then shifts both
// 16-bit frame words out MSB-first under one SYNC_n-framed transfer.
module pmod_da2_tx
  import pmod_da2_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter int         SIGNED_IN = 1,
  parameter logic [1:0] PD_MODE   = PD_NORMAL
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              tx_done,
  output logic              SClk,
  output logic              SYNC_n,
  output logic              D0,
  output logic              D1,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a pair is taken on any clk edge where din_valid && din_ready;
  // din_ready is high exactly while the FSM sits in IDLE.

  tx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] sh_a_q, sh_a_d;
  logic [FRAME_BITS-1:0] sh_b_q, sh_b_d;
  logic [4:0]            bitcnt_q, bitcnt_d;
  logic                  sync_n_q, sync_n_d;
  logic                  d0_q, d0_d;
  logic                  d1_q, d1_d;
  logic                  tx_done_q, tx_done_d;
  logic                  rise_ev, fall_ev;

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .Reset     (Reset),
    .sclk_o    (SClk),
    .rise_ev_o (rise_ev),
    .fall_ev_o (fall_ev)
  );

  always_comb begin
    state_d   = state_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    bitcnt_d  = bitcnt_q;
    sync_n_d  = sync_n_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    tx_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          sh_a_d  = frame_word(din_a, SIGNED_IN != 0, PD_MODE);
          sh_b_d  = frame_word(din_b, SIGNED_IN != 0, PD_MODE);
          state_d = ARM;
        end
      end
      ARM: begin
        if (rise_ev) begin
          sync_n_d = 1'b0;
          d0_d     = sh_a_q[FRAME_BITS-1];
          d1_d     = sh_b_q[FRAME_BITS-1];
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // The DAC latches on the fall; the next bit is presented on the rise.
        if (fall_ev) begin
          sh_a_d   = {sh_a_q[FRAME_BITS-2:0], 1'b0};
          sh_b_d   = {sh_b_q[FRAME_BITS-2:0], 1'b0};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'(FRAME_BITS - 1)) state_d = DONE;
        end
        if (rise_ev && (bitcnt_q < 5'(FRAME_BITS))) begin
          d0_d = sh_a_q[FRAME_BITS-1];
          d1_d = sh_b_q[FRAME_BITS-1];
        end
      end
      DONE: begin
        if (rise_ev) begin
          sync_n_d  = 1'b1;
          d0_d      = 1'b0;
          d1_d      = 1'b0;
          tx_done_d = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (rise_ev) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      bitcnt_q  <= '0;
      sync_n_q  <= 1'b1;
      d0_q      <= 1'b0;
      d1_q      <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      bitcnt_q  <= bitcnt_d;
      sync_n_q  <= sync_n_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign din_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = tx_done_q;
  assign SYNC_n      = sync_n_q;
  assign D0          = d0_q;
  assign D1          = d1_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pmod_da2_tx.sv
// Directed bench for pmod_da2_tx: a default (signed, PD normal) instance and a
// raw-input instance with PD_MODE=11 share stimulus; one monitor follows the selected one.
module tb_pmod_da2_tx;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [11:0] din_a = '0;
  logic [11:0] din_b = '0;
  logic        din_valid = 1'b0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  logic       ready_1, busy_1, done_1, sclk_1, sync_1, d0_1, d1_1;
  logic       ready_2, busy_2, done_2, sclk_2, sync_2, d0_2, d1_2;
  logic [2:0] state_1, state_2;

  pmod_da2_tx #(.CLK_DIV(4), .SIGNED_IN(1), .PD_MODE(2'b00)) u_dut (
    .clk(clk), .Reset(Reset), .din_a(din_a), .din_b(din_b), .din_valid(din_valid),
    .din_ready(ready_1), .busy(busy_1), .tx_done(done_1), .SClk(sclk_1),
    .SYNC_n(sync_1), .D0(d0_1), .D1(d1_1), .dbg_state_o(state_1)
  );

  pmod_da2_tx #(.CLK_DIV(4), .SIGNED_IN(0), .PD_MODE(2'b11)) u_dut_raw (
    .clk(clk), .Reset(Reset), .din_a(din_a), .din_b(din_b), .din_valid(din_valid),
    .din_ready(ready_2), .busy(busy_2), .tx_done(done_2), .SClk(sclk_2),
    .SYNC_n(sync_2), .D0(d0_2), .D1(d1_2), .dbg_state_o(state_2)
  );

  logic m_ready, m_busy, m_done, m_sclk, m_sync, m_d0, m_d1;
  assign m_ready = sel ? ready_2 : ready_1;
  assign m_busy  = sel ? busy_2  : busy_1;
  assign m_done  = sel ? done_2  : done_1;
  assign m_sclk  = sel ? sclk_2  : sclk_1;
  assign m_sync  = sel ? sync_2  : sync_1;
  assign m_d0    = sel ? d0_2    : d0_1;
  assign m_d1    = sel ? d1_2    : d1_1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [39:0] frm_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0, falls = 0, low_cnt = 0, high_cnt = 0, last_low = 0, last_gap = 0;
  int last_rise = 0, sclk_period = 0, d0_bad = 0, rdy_bad = 0, done_cnt = 0;
  int sync_fall_cyc = 0, acc_cyc = 0;
  logic [15:0] cap_a = '0, cap_b = '0;
  logic prev_sclk = 1'b1, prev_sync = 1'b1, prev_d0 = 1'b0;

  // Monitor samples on the falling clk edge, away from every DUT update.
  always @(negedge clk) begin
    cyc++;
    if (prev_sync && !m_sync) begin
      last_gap = high_cnt;
      sync_fall_cyc = cyc;
      falls = 0; low_cnt = 0; cap_a = '0; cap_b = '0;
    end
    if (!prev_sync && m_sync) begin
      last_low = low_cnt;
      frm_q.push_back({8'(falls), cap_a, cap_b});
      high_cnt = 0;
    end
    if (prev_sclk && !m_sclk && !m_sync) begin
      cap_a = {cap_a[14:0], m_d0};
      cap_b = {cap_b[14:0], m_d1};
      falls++;
    end
    if (!prev_sclk && m_sclk) begin
      if (last_rise > 0) sclk_period = cyc - last_rise;
      last_rise = cyc;
    end
    if ((m_d0 != prev_d0) && !(!prev_sclk && m_sclk) && !Reset) d0_bad++;
    if (m_ready == m_busy) rdy_bad++;
    if (m_done) done_cnt++;
    if (!m_sync) low_cnt++; else high_cnt++;
    prev_sclk = m_sclk;
    prev_sync = m_sync;
    prev_d0   = m_d0;
  end

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic accept_pair(input logic [11:0] a, input logic [11:0] b, input bit keep);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!m_ready && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    if (!m_ready) check("accept_timeout", 32'd0, 32'd1);
    din_a = a;
    din_b = b;
    din_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep) din_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    logic [39:0] f;
    logic [31:0] e;
    int n;
    n = 0;
    while (frm_q.size() == 0 && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    if (frm_q.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    f = frm_q.pop_front();
    e = exp_q.pop_front();
    check({tag, "_bits"}, 32'(f[39:32]), 32'd16);
    check({tag, "_d0"}, 32'(f[31:16]), 32'(e[31:16]));
    check({tag, "_d1"}, 32'(f[15:0]), 32'(e[15:0]));
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int d_base, bad_base, lat;
    logic [39:0] part;

    repeat (3) @(negedge clk);
    #1;
    check("rst_sclk", 32'(sclk_1), 32'd1);
    check("rst_sync", 32'(sync_1), 32'd1);
    check("rst_d0d1", 32'({d0_1, d1_1}), 32'd0);
    check("rst_txdone", 32'(done_1), 32'd0);
    check("rst_ready", 32'(ready_1), 32'd1);
    check("rst_busy", 32'(busy_1), 32'd0);
    check("rst_state", 32'(state_1), 32'd0);
    Reset = 1'b0;
    idle_clks(5);

    // Test 1: signed full-scale pair -> 0x0FFF / 0x0000
    d_base = done_cnt;
    accept_pair(12'h7FF, 12'h800, 1'b0);
    exp_q.push_back(32'h0FFF_0000);
    check_frame("t1");
    lat = sync_fall_cyc - acc_cyc - 1;
    check("t1_latency_le9", 32'(lat >= 1 && lat <= 9), 32'd1);
    check("t1_sync_low", 32'(last_low), 32'd128);
    idle_clks(12);
    check("t1_txdone", 32'(done_cnt - d_base), 32'd1);

    // Test 2: raw input, PD=11 on the second instance
    sel = 1'b1;
    bad_base = d0_bad;
    accept_pair(12'hA5C, 12'h5A3, 1'b0);
    exp_q.push_back(32'h3A5C_35A3);
    check_frame("t2");
    check("t2_sclk_period", 32'(sclk_period), 32'd8);
    check("t2_d0_on_rise", 32'(d0_bad - bad_base), 32'd0);
    idle_clks(20);
    sel = 1'b0;
    idle_clks(4);

    // Test 3: din_valid held high across two frames
    d_base = done_cnt;
    accept_pair(12'h000, 12'h000, 1'b1);
    accept_pair(12'h001, 12'h001, 1'b0);
    exp_q.push_back(32'h0800_0800);
    exp_q.push_back(32'h0801_0801);
    check_frame("t3a");
    check_frame("t3b");
    check("t3_gap_ge8", 32'(last_gap >= 8), 32'd1);
    idle_clks(12);
    check("t3_txdone", 32'(done_cnt - d_base), 32'd2);
    check("t3_ready_idle_only", 32'(rdy_bad), 32'd0);

    // Test 4: valid pulse during SHIFT is ignored
    d_base = done_cnt;
    accept_pair(12'h456, 12'h321, 1'b0);
    idle_clks(40);
    check("t4_busy_in_shift", 32'(busy_1), 32'd1);
    din_a = 12'h123;
    din_valid = 1'b1;
    @(negedge clk); #1;
    din_valid = 1'b0;
    exp_q.push_back(32'h0C56_0B21);
    check_frame("t4");
    idle_clks(300);
    check("t4_no_extra_frame", 32'(frm_q.size()), 32'd0);
    check("t4_txdone", 32'(done_cnt - d_base), 32'd1);

    // Test 5: asynchronous reset after the 7th SClk fall
    accept_pair(12'h555, 12'hAAA, 1'b0);
    begin
      int n;
      n = 0;
      while (falls != 7 && n < 400) begin
        @(negedge clk); #1;
        n++;
      end
    end
    check("t5_reach_fall7", 32'(falls), 32'd7);
    #1 Reset = 1'b1;
    #1;
    check("t5_rst_sync", 32'(sync_1), 32'd1);
    check("t5_rst_d0d1", 32'({d0_1, d1_1}), 32'd0);
    check("t5_rst_sclk", 32'(sclk_1), 32'd1);
    idle_clks(3);
    if (frm_q.size() > 0) begin
      part = frm_q.pop_front();
      check("t5_partial_falls", 32'(part[39:32]), 32'd7);
    end else begin
      check("t5_partial_missing", 32'd0, 32'd1);
    end
    Reset = 1'b0;
    idle_clks(1);
    check("t5_busy", 32'(busy_1), 32'd0);
    check("t5_ready", 32'(ready_1), 32'd1);
    accept_pair(12'h0AB, 12'hF00, 1'b0);
    exp_q.push_back(32'h08AB_0700);
    check_frame("t5");
    idle_clks(12);

    // Test 6: input change right after accept does not reach the frame
    accept_pair(12'h3C3, 12'h111, 1'b0);
    din_a = 12'hFFF;
    din_b = 12'h000;
    exp_q.push_back(32'h0BC3_0911);
    check_frame("t6");
    idle_clks(12);
    check("all_d0_on_rise", 32'(d0_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
